// File: rtl/branch_resolver.sv
// Resolves branches/jumps at EX against the fetch-stage prediction carried down the pipe.
// Drives flush/redirect on a mispredict, a one-shot predictor update, and saturating counters.
module branch_resolver #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             if_valid_i,
  input  logic [XLEN-1:0]  pc_if_i,
  input  logic             pred_hit_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  input  logic [31:0]      inst_ex_i,
  input  logic [XLEN-1:0]  pc_ex_i,
  input  logic             BrEq_i,
  input  logic             BrLt_i,
  input  logic [XLEN-1:0]  alu_i,
  output logic             flush_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             upd_valid_o,
  output logic             upd_taken_o,
  output logic [XLEN-1:0]  upd_pc_o,
  output logic [XLEN-1:0]  upd_target_o,
  output logic             hit_ex_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            hit;
    logic [XLEN-1:0] pred_pc;
  } meta_t;

  meta_t            id_q, id_d;
  meta_t            ex_q, ex_d;
  logic             resolved_q, resolved_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             is_branch;
  logic             is_jump;
  logic             actual_taken;
  logic             active;
  logic [XLEN-1:0]  pc_plus4;

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q       <= '0;
      ex_q       <= '0;
      resolved_q <= 1'b0;
      br_cnt_q   <= '0;
      mis_cnt_q  <= '0;
    end else begin
      id_q       <= id_d;
      ex_q       <= ex_d;
      resolved_q <= resolved_d;
      br_cnt_q   <= br_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
    end
  end

  assign opcode    = inst_ex_i[6:0];
  assign funct3    = inst_ex_i[14:12];
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign active    = ex_q.valid && !resolved_q;
  assign pc_plus4  = pc_ex_i + XLEN'(4);

  // Actual outcome from the comparator flags
  always_comb begin
    actual_taken = 1'b0;
    if (is_jump) begin
      actual_taken = 1'b1;
    end else begin
      unique case (funct3)
        3'b000:         actual_taken = BrEq_i;
        3'b001:         actual_taken = !BrEq_i;
        3'b100, 3'b110: actual_taken = BrLt_i;
        3'b101, 3'b111: actual_taken = !BrLt_i;
        default:        actual_taken = 1'b0;
      endcase
    end
  end

  // Resolution outputs, valid only in the first EX cycle of an instruction
  always_comb begin
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    upd_valid_o   = 1'b0;
    upd_taken_o   = 1'b0;
    upd_pc_o      = '0;
    upd_target_o  = '0;
    if (active) begin
      if (is_branch || is_jump) begin
        upd_valid_o  = 1'b1;
        upd_taken_o  = actual_taken;
        upd_pc_o     = pc_ex_i;
        upd_target_o = alu_i;
        if (ex_q.hit && !actual_taken) begin
          redirect_o    = 1'b1;
          redirect_pc_o = pc_plus4;
        end else if (actual_taken && (!ex_q.hit || (ex_q.pred_pc != alu_i))) begin
          redirect_o    = 1'b1;
          redirect_pc_o = alu_i;
        end
      end else if (ex_q.hit) begin
        // Stale BTB alias on a non-control instruction
        redirect_o    = 1'b1;
        redirect_pc_o = pc_plus4;
      end
    end
  end

  assign flush_o  = redirect_o;
  assign hit_ex_o = ex_q.valid && ex_q.hit;

  // Metadata advance; flush wins over stall
  always_comb begin
    id_d       = id_q;
    ex_d       = ex_q;
    resolved_d = resolved_q;
    if (flush_o) begin
      id_d.valid = 1'b0;
      ex_d.valid = 1'b0;
      resolved_d = 1'b0;
    end else if (!stall_i) begin
      ex_d       = id_q;
      id_d       = '{valid: if_valid_i, pc: pc_if_i, hit: pred_hit_i, pred_pc: pred_pc_i};
      resolved_d = 1'b0;
    end else if (upd_valid_o || redirect_o) begin
      resolved_d = 1'b1;
    end
  end

  // Saturating performance counters
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_valid_o && (br_cnt_q != {CNT_W{1'b1}})) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (redirect_o && (mis_cnt_q != {CNT_W{1'b1}})) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  assign br_cnt_o  = br_cnt_q;
  assign mis_cnt_o = mis_cnt_q;

  // EX uses the PC presented with the instruction; carried PC and other fields are not needed here
  logic unused_ok;
  assign unused_ok = ^{inst_ex_i[31:15], inst_ex_i[11:7], ex_q.pc};

endmodule
